// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: IDCODE/BYPASS plus an address/data/control/status
// register set that turns debugger scans into single bus transaction requests.
package jtag_dr_bank_pkg;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR_SCAN, CAPTURE_DR, SHIFT_DR,
    EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, SELECT_IR_SCAN, CAPTURE_IR,
    SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_ctrl_fsm_t;

  typedef enum logic [2:0] {
    BYPASS, IDCODE, ADDR_REGISTER, DATA_WR_REGISTER, DATA_RD_REGISTER,
    CTRL_REGISTER, STATUS_REGISTER
  } ir_decoding_t;
endpackage

module jtag_dr_bank
  import jtag_dr_bank_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_010F
) (
  input  logic              tck,
  input  logic              trstn,
  input  logic              tdi,
  output logic              tdo,
  input  tap_ctrl_fsm_t     tap_state,
  input  ir_decoding_t      ir_dec,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              txn_write,
  output logic [1:0]        txn_size,
  output logic              txn_start,
  input  logic              txn_done,
  input  logic              txn_err,
  input  logic [DATA_W-1:0] rd_data
);

  localparam int AD_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int SR_W = (AD_W > 32) ? AD_W : 32;

  logic [SR_W-1:0]   sr_q, sr_d, cap_val, sr_up;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, data_rd_q, data_rd_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, drop_q, drop_d;
  logic              tdo_q;
  int                len;

  // Selected length and capture value; unknown decodes fall back to BYPASS.
  always_comb begin
    len     = 1;
    cap_val = '0;
    case (ir_dec)
      IDCODE:           begin len = 32;     cap_val[31:0] = IDCODE_VAL; end
      ADDR_REGISTER:    begin len = ADDR_W; cap_val[ADDR_W-1:0] = addr_q; end
      DATA_WR_REGISTER: begin len = DATA_W; cap_val[DATA_W-1:0] = wr_data_q; end
      DATA_RD_REGISTER: begin len = DATA_W; cap_val[DATA_W-1:0] = data_rd_q; end
      CTRL_REGISTER:    begin len = 4;      cap_val[3:0] = {size_q, write_q, 1'b0}; end
      STATUS_REGISTER:  begin len = 4;      cap_val[3:0] = {drop_q, err_q, done_q, busy_q}; end
      default:          begin len = 1;      cap_val = '0; end
    endcase
  end

  assign sr_up = {1'b0, sr_q[SR_W-1:1]};

  // Only the low len bits take part in capture/shift; the rest hold.
  always_comb begin
    sr_d = sr_q;
    for (int i = 0; i < SR_W; i++) begin
      if (tap_state == CAPTURE_DR && i < len)
        sr_d[i] = cap_val[i];
      else if (tap_state == SHIFT_DR && i < len)
        sr_d[i] = (i == len - 1) ? tdi : sr_up[i];
    end
  end

  always_comb begin
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    data_rd_d = data_rd_q;
    write_d   = write_q;
    size_d    = size_q;
    start_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    drop_d    = drop_q;

    // Reading status clears the sticky bits; any set below in the same cycle wins.
    if (tap_state == CAPTURE_DR && ir_dec == STATUS_REGISTER) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      drop_d = 1'b0;
    end

    if (tap_state == UPDATE_DR) begin
      case (ir_dec)
        ADDR_REGISTER:    addr_d    = sr_q[ADDR_W-1:0];
        DATA_WR_REGISTER: wr_data_d = sr_q[DATA_W-1:0];
        CTRL_REGISTER: begin
          size_d  = sr_q[3:2];
          write_d = sr_q[1];
          if (sr_q[0]) begin
            if (busy_q) drop_d = 1'b1;
            else begin
              start_d = 1'b1;
              busy_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (txn_done && busy_q) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      if (txn_err)       err_d     = 1'b1;
      else if (!write_q) data_rd_d = rd_data;
    end
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      sr_q      <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      data_rd_q <= '0;
      write_q   <= 1'b0;
      size_q    <= 2'b00;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      data_rd_q <= data_rd_d;
      write_q   <= write_d;
      size_q    <= size_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(negedge tck or negedge trstn) begin
    if (!trstn) tdo_q <= 1'b0;
    else        tdo_q <= (tap_state == SHIFT_DR) ? sr_q[0] : 1'b0;
  end

  assign tdo       = tdo_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;
  assign txn_write = write_q;
  assign txn_size  = size_q;
  assign txn_start = start_q;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Directed bench for jtag_dr_bank: drives TAP state/IR directly and checks scans.
module tb_jtag_dr_bank;
  import jtag_dr_bank_pkg::*;

  logic          tck = 1'b0;
  logic          trstn, tdi, tdo;
  tap_ctrl_fsm_t tap_state;
  ir_decoding_t  ir_dec;
  logic [31:0]   addr, wr_data, rd_data;
  logic          txn_write, txn_start, txn_done, txn_err;
  logic [1:0]    txn_size;
  logic [63:0]   dout;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 tck = ~tck;

  jtag_dr_bank #(.ADDR_W(32), .DATA_W(32), .IDCODE_VAL(32'h0000_010F)) dut (
    .tck(tck), .trstn(trstn), .tdi(tdi), .tdo(tdo),
    .tap_state(tap_state), .ir_dec(ir_dec),
    .addr(addr), .wr_data(wr_data), .txn_write(txn_write), .txn_size(txn_size),
    .txn_start(txn_start), .txn_done(txn_done), .txn_err(txn_err), .rd_data(rd_data)
  );

  // Capture, shift len bits LSB-first (recording tdo), optional update.
  task automatic dr_scan(input ir_decoding_t ir, input int len, input logic [63:0] din,
                         input bit upd, input bit cap_done, input bit cap_err,
                         output logic [63:0] dout_o);
    dout_o    = '0;
    ir_dec    = ir;
    tap_state = CAPTURE_DR;
    txn_done  = cap_done;
    txn_err   = cap_err;
    @(posedge tck); #1;
    txn_done = 1'b0;
    txn_err  = 1'b0;
    for (int i = 0; i < len; i++) begin
      tap_state = SHIFT_DR;
      tdi       = din[i];
      @(negedge tck); #1;
      dout_o[i] = tdo;
      @(posedge tck); #1;
    end
    tdi       = 1'b0;
    tap_state = EXIT1_DR;
    @(posedge tck); #1;
    if (upd) begin
      tap_state = UPDATE_DR;
      @(posedge tck); #1;
    end
    tap_state = RUN_TEST_IDLE;
  endtask

  task automatic pulse_done(input bit err);
    txn_done = 1'b1;
    txn_err  = err;
    @(posedge tck); #1;
    txn_done = 1'b0;
    txn_err  = 1'b0;
  endtask

  task automatic test_reset;
    trstn = 1'b0; tdi = 1'b0; tap_state = TEST_LOGIC_RESET; ir_dec = BYPASS;
    txn_done = 1'b0; txn_err = 1'b0; rd_data = '0;
    repeat (3) @(posedge tck);
    #1;
    n_tests++;
    if ({addr, wr_data, txn_write, txn_size, txn_start, tdo} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h wr=%h w=%b sz=%b st=%b tdo=%b expected all 0",
               addr, wr_data, txn_write, txn_size, txn_start, tdo);
    end
    #2 trstn = 1'b1;
    @(posedge tck); #1;
    tap_state = RUN_TEST_IDLE;
    n_tests++;
    if (txn_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_start: got %b expected 0", txn_start);
    end
    dr_scan(STATUS_REGISTER, 4, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[3:0] !== 4'b0000) begin
      n_fail++; $display("FAIL reset_status: got %b expected 0000", dout[3:0]);
    end
  endtask

  task automatic test_idcode_bypass;
    dr_scan(IDCODE, 40, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[39:0] !== 40'h00_0000_010F) begin
      n_fail++; $display("FAIL idcode: got %h expected 000000010f", dout[39:0]);
    end
    dr_scan(BYPASS, 2, 64'h1, 0, 0, 0, dout);
    n_tests++;
    if (dout[1:0] !== 2'b10) begin
      n_fail++; $display("FAIL bypass: got %b expected 10", dout[1:0]);
    end
    dr_scan(ir_decoding_t'(3'd7), 3, 64'h3, 0, 0, 0, dout);
    n_tests++;
    if (dout[2:0] !== 3'b110) begin
      n_fail++; $display("FAIL unknown_ir_bypass: got %b expected 110", dout[2:0]);
    end
  endtask

  task automatic test_addr;
    dr_scan(ADDR_REGISTER, 32, 64'hDEAD_BEEF, 1, 0, 0, dout);
    n_tests++;
    if (addr !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL addr_update: got %h expected deadbeef", addr);
    end
    dr_scan(ADDR_REGISTER, 32, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL addr_recapture: got %h expected deadbeef", dout[31:0]);
    end
  endtask

  task automatic test_write_txn;
    dr_scan(DATA_WR_REGISTER, 32, 64'hA5A5_5A5A, 1, 0, 0, dout);
    n_tests++;
    if (wr_data !== 32'hA5A5_5A5A) begin
      n_fail++; $display("FAIL wr_data_update: got %h expected a5a55a5a", wr_data);
    end
    dr_scan(CTRL_REGISTER, 4, 64'hB, 1, 0, 0, dout);
    n_tests++;
    if ({txn_start, txn_write, txn_size} !== 4'b1110) begin
      n_fail++; $display("FAIL wr_start: got st/w/sz=%b expected 1110", {txn_start, txn_write, txn_size});
    end
    @(posedge tck); #1;
    n_tests++;
    if (txn_start !== 1'b0) begin
      n_fail++; $display("FAIL wr_start_one_cycle: got %b expected 0", txn_start);
    end
    dr_scan(STATUS_REGISTER, 4, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[3:0] !== 4'b0001) begin
      n_fail++; $display("FAIL wr_status_busy: got %b expected 0001", dout[3:0]);
    end
    dr_scan(CTRL_REGISTER, 4, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[3:0] !== 4'b1010) begin
      n_fail++; $display("FAIL ctrl_capture: got %b expected 1010", dout[3:0]);
    end
    pulse_done(0);
    dr_scan(STATUS_REGISTER, 4, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[3:0] !== 4'b0010) begin
      n_fail++; $display("FAIL wr_status_done: got %b expected 0010", dout[3:0]);
    end
  endtask

  task automatic test_read_txn;
    dr_scan(CTRL_REGISTER, 4, 64'h9, 1, 0, 0, dout);
    n_tests++;
    if ({txn_start, txn_write, txn_size} !== 4'b1010) begin
      n_fail++; $display("FAIL rd_start: got st/w/sz=%b expected 1010", {txn_start, txn_write, txn_size});
    end
    rd_data = 32'h1234_5678;
    pulse_done(0);
    dr_scan(DATA_RD_REGISTER, 32, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[31:0] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rd_data: got %h expected 12345678", dout[31:0]);
    end
    dr_scan(STATUS_REGISTER, 4, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[3:0] !== 4'b0010) begin
      n_fail++; $display("FAIL rd_status_done: got %b expected 0010", dout[3:0]);
    end
    dr_scan(STATUS_REGISTER, 4, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[3:0] !== 4'b0000) begin
      n_fail++; $display("FAIL rd_status_cleared: got %b expected 0000", dout[3:0]);
    end
  endtask

  task automatic test_busy_drop;
    dr_scan(CTRL_REGISTER, 4, 64'h9, 1, 0, 0, dout);
    n_tests++;
    if (txn_start !== 1'b1) begin
      n_fail++; $display("FAIL busy_first_start: got %b expected 1", txn_start);
    end
    dr_scan(CTRL_REGISTER, 4, 64'h9, 1, 0, 0, dout);
    n_tests++;
    if (txn_start !== 1'b0) begin
      n_fail++; $display("FAIL busy_no_start: got %b expected 0", txn_start);
    end
    dr_scan(ADDR_REGISTER, 32, 64'h0000_1234, 1, 0, 0, dout);
    n_tests++;
    if (addr !== 32'h0000_1234) begin
      n_fail++; $display("FAIL busy_addr_write: got %h expected 00001234", addr);
    end
    rd_data = 32'hCAFE_F00D;
    dr_scan(STATUS_REGISTER, 4, 64'h0, 0, 1, 1, dout);
    n_tests++;
    if (dout[3:0] !== 4'b1001) begin
      n_fail++; $display("FAIL busy_status_drop: got %b expected 1001", dout[3:0]);
    end
    dr_scan(STATUS_REGISTER, 4, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[3:0] !== 4'b0110) begin
      n_fail++; $display("FAIL err_set_wins: got %b expected 0110", dout[3:0]);
    end
    dr_scan(DATA_RD_REGISTER, 32, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[31:0] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL err_no_rd_load: got %h expected 12345678", dout[31:0]);
    end
    rd_data = 32'h0000_0055;
    pulse_done(0);
    dr_scan(STATUS_REGISTER, 4, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[3:0] !== 4'b0000) begin
      n_fail++; $display("FAIL idle_done_ignored: got %b expected 0000", dout[3:0]);
    end
    dr_scan(DATA_RD_REGISTER, 32, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[31:0] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL idle_done_no_load: got %h expected 12345678", dout[31:0]);
    end
  endtask

  task automatic test_reset_mid_shift;
    dr_scan(CTRL_REGISTER, 4, 64'hB, 1, 0, 0, dout);
    @(posedge tck); #1;
    ir_dec    = DATA_WR_REGISTER;
    tap_state = CAPTURE_DR;
    @(posedge tck); #1;
    tap_state = SHIFT_DR;
    tdi       = 1'b1;
    repeat (10) begin @(posedge tck); #1; end
    @(negedge tck); #1;
    trstn = 1'b0;
    #1;
    n_tests++;
    if ({addr, wr_data, txn_write, txn_size, txn_start, tdo} !== '0) begin
      n_fail++;
      $display("FAIL midshift_reset: got addr=%h wr=%h w=%b sz=%b st=%b tdo=%b expected all 0",
               addr, wr_data, txn_write, txn_size, txn_start, tdo);
    end
    tap_state = RUN_TEST_IDLE;
    tdi       = 1'b0;
    #1 trstn = 1'b1;
    @(posedge tck); #1;
    n_tests++;
    if ({txn_start, wr_data} !== '0) begin
      n_fail++; $display("FAIL post_release: got st=%b wr=%h expected 0/0", txn_start, wr_data);
    end
    pulse_done(0);
    dr_scan(STATUS_REGISTER, 4, 64'h0, 0, 0, 0, dout);
    n_tests++;
    if (dout[3:0] !== 4'b0000) begin
      n_fail++; $display("FAIL reset_drops_busy: got %b expected 0000", dout[3:0]);
    end
  endtask

  initial begin
    test_reset;
    test_idcode_bypass;
    test_addr;
    test_write_txn;
    test_read_txn;
    test_busy_drop;
    test_reset_mid_shift;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_dr_bank.md
JTAG_DR_BANK -- requirements
Module: jtag_dr_bank

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address register width (8..64).
REQ-002 The block SHALL have parameter DATA_W, default 32, write/read data register width (8..64).
REQ-003 The block SHALL have parameter IDCODE_VAL, default 32'h0000_010F, value captured for IDCODE.
REQ-004 The block SHALL have port tck  input  1  TAP clock.
REQ-005 The block SHALL have port trstn  input  1  reset trstn, asynchronous, active-low.
REQ-006 The block SHALL have ports tdi  input  1  serial in, and tdo  output  1  serial out.
REQ-007 The block SHALL have port tap_state  input  tap_ctrl_fsm_t  current TAP state.
REQ-008 The block SHALL have port ir_dec  input  ir_decoding_t  decoded instruction: BYPASS, IDCODE, ADDR_REGISTER, DATA_WR_REGISTER, DATA_RD_REGISTER, CTRL_REGISTER, STATUS_REGISTER.
REQ-009 The block SHALL have ports addr  output  ADDR_W  and wr_data  output  DATA_W  updated transaction address/write data.
REQ-010 The block SHALL have ports txn_write  output  1  (1=write) and txn_size  output  2  (log2 bytes).
REQ-011 The block SHALL have port txn_start  output  1  one-tck transaction request pulse.
REQ-012 The block SHALL have ports txn_done  input  1, txn_err  input  1, rd_data  input  DATA_W  transaction completion, sampled on posedge tck.

Function
REQ-013 Shift register sr SHALL be max(ADDR_W,DATA_W,32) bits; selected length L: BYPASS 1, IDCODE 32, ADDR ADDR_W, DATA_WR/DATA_RD DATA_W, CTRL 4, STATUS 4; any other ir_dec SHALL behave as BYPASS.
REQ-014 CAPTURE_DR SHALL load sr[L-1:0]: BYPASS 0, IDCODE IDCODE_VAL, ADDR addr, DATA_WR wr_data, DATA_RD data_rd, CTRL {txn_size,txn_write,1'b0}, STATUS {drop,err,done,busy} (bit0=busy).
REQ-015 SHIFT_DR SHALL shift right LSB-first on posedge tck: sr[L-1]<=tdi, sr[i]<=sr[i+1]; bits >=L SHALL hold.
REQ-016 tdo SHALL be registered on negedge tck: sr[0] while tap_state==SHIFT_DR, else 0.
REQ-017 UPDATE_DR SHALL load: ADDR addr<=sr[ADDR_W-1:0]; DATA_WR wr_data<=sr[DATA_W-1:0]; CTRL txn_size<=sr[3:2], txn_write<=sr[1]; IDCODE, BYPASS, DATA_RD, STATUS SHALL update nothing.
REQ-018 CTRL UPDATE_DR with sr[0]=1 and busy=0 SHALL pulse txn_start high for exactly the next tck cycle and set busy.
REQ-019 CTRL UPDATE_DR with sr[0]=1 and busy=1 SHALL NOT pulse txn_start and SHALL set sticky drop.
REQ-020 txn_done=1 while busy SHALL clear busy, set sticky done, set sticky err if txn_err=1, and load data_rd<=rd_data if txn_write=0 and txn_err=0.
REQ-021 txn_done while busy=0 SHALL be ignored.
REQ-022 STATUS CAPTURE_DR SHALL clear done, err, drop one cycle later; a set event in that same cycle SHALL win (bit remains 1).
REQ-023 UPDATE_DR writes to addr/wr_data/txn_write/txn_size while busy=1 SHALL be applied (host is responsible for ordering).
REQ-024 All state except tdo SHALL be on posedge tck; no combinational path from tdi to tdo.

Reset
REQ-025 trstn low SHALL asynchronously clear sr, addr, wr_data, data_rd, txn_write, txn_size, busy, done, err, drop, txn_start, tdo to 0.
REQ-026 trstn low mid-transaction SHALL drop busy; a later txn_done SHALL be ignored per REQ-021.
REQ-027 First posedge after trstn release SHALL behave as a normal cycle; no start pulse is generated by reset.

Verification
REQ-028 IDCODE, CAPTURE then 32 SHIFT_DR cycles, tdi=0 -> tdo serially yields 0x0000010F LSB-first, then zeros.
REQ-029 ADDR_REGISTER shift 0xDEADBEEF, UPDATE_DR -> addr=0xDEADBEEF; recapture and shift -> tdo returns 0xDEADBEEF.
REQ-030 CTRL shift 4'b1011 (size=2, write=1, start=1), UPDATE_DR -> txn_start high one cycle, STATUS capture reads 4'b0001.
REQ-031 Read txn (CTRL 4'b1001), rd_data=0x12345678, txn_done=1 -> DATA_RD shift returns 0x12345678, STATUS 4'b0010, second STATUS read 4'b0000.
REQ-032 Start while busy -> no txn_start, STATUS 4'b1001; txn_done with txn_err=1 on same cycle as STATUS capture -> err reads 1 on next capture.
REQ-033 trstn asserted during SHIFT_DR of DATA_WR -> all outputs 0 immediately, wr_data stays 0 after release.
